hazard_ctrl: RTL and testbench

- Pipeline interlock/flush controller. Generates the `STALL` bubble request consumed by the ID/EX register, plus PC and IF/ID write enables and the IF/ID flush.
- Consumes the control fields that leave ID/EX (`MemR`, `RegW`, destination register) and the branch/jump resolution from EX.
- Tracks the multi-cycle multiply/divide unit so that HI/LO readers in ID wait for completion.
- Keeps saturating performance counters for stall cycles and flushes.

---
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline interlock/flush controller
// Load-use and HI/LO interlocks, redirect flush, mul/div busy tracking, perf counters.
module hazard_ctrl #(
   parameter int MD_CYCLES   = 32,
   parameter int STALL_CNT_W = 32,
   parameter int FLUSH_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic                   id_uses_rs,
   input  logic                   id_uses_rt,
   input  logic                   id_uses_hilo,
   input  logic [4:0]             ex_rd,
   input  logic                   ex_memr,
   input  logic                   ex_regw,
   input  logic                   ex_redirect,
   input  logic                   md_start,
   input  logic                   cnt_clr,
   output logic                   STALL,
   output logic                   pc_wr,
   output logic                   if_id_wr,
   output logic                   if_id_flush,
   output logic                   load_stall,
   output logic                   hilo_stall,
   output logic                   md_busy,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic [FLUSH_CNT_W-1:0] flush_cnt
);

   logic [7:0] md_cnt;
   logic       md_pend;
   logic       lu_hit;
   logic       hl_hit;

   assign md_pend = md_start | (md_cnt != 8'd0);
   assign lu_hit  = ex_memr & ex_regw & (ex_rd != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
   assign hl_hit  = id_uses_hilo & md_pend;

   always_comb begin
      STALL       = 1'b0;
      pc_wr       = 1'b1;
      if_id_wr    = 1'b1;
      if_id_flush = 1'b0;
      load_stall  = 1'b0;
      hilo_stall  = 1'b0;
      md_busy     = 1'b0;
      if (rst) begin
         STALL       = 1'b1;
         pc_wr       = 1'b0;
         if_id_wr    = 1'b0;
         if_id_flush = 1'b1;
      end else begin
         md_busy = md_pend;
         // Redirect wins: the ID instruction is wrong-path, so its hazards are moot.
         if (ex_redirect) begin
            STALL       = 1'b1;
            if_id_flush = 1'b1;
         end else if (hl_hit) begin
            STALL      = 1'b1;
            pc_wr      = 1'b0;
            if_id_wr   = 1'b0;
            hilo_stall = 1'b1;
            load_stall = lu_hit;
         end else if (lu_hit) begin
            STALL      = 1'b1;
            pc_wr      = 1'b0;
            if_id_wr   = 1'b0;
            load_stall = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt       <= 8'd0;
         stall_cycles <= '0;
         flush_cnt    <= '0;
      end else begin
         // A new op supersedes any op still in flight.
         if (md_start)
            md_cnt <= 8'(MD_CYCLES - 1);
         else if (md_cnt != 8'd0)
            md_cnt <= md_cnt - 8'd1;

         if (cnt_clr)
            stall_cycles <= '0;
         else if (!pc_wr && (stall_cycles != '1))
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);

         if (cnt_clr)
            flush_cnt <= '0;
         else if (ex_redirect && (flush_cnt != '1))
            flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Cycle-level reference model plus directed literal checks and random stimulus.
module tb_hazard_ctrl;
   localparam int MD  = 4;
   localparam int SW  = 6;
   localparam int FW  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic id_uses_rs = 0, id_uses_rt = 0, id_uses_hilo = 0;
   logic ex_memr = 0, ex_regw = 0, ex_redirect = 0, md_start = 0, cnt_clr = 0;
   logic STALL, pc_wr, if_id_wr, if_id_flush, load_stall, hilo_stall, md_busy;
   logic [SW-1:0] stall_cycles;
   logic [FW-1:0] flush_cnt;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(.MD_CYCLES(MD), .STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
      .ex_rd(ex_rd), .ex_memr(ex_memr), .ex_regw(ex_regw), .ex_redirect(ex_redirect),
      .md_start(md_start), .cnt_clr(cnt_clr), .STALL(STALL), .pc_wr(pc_wr),
      .if_id_wr(if_id_wr), .if_id_flush(if_id_flush), .load_stall(load_stall),
      .hilo_stall(hilo_stall), .md_busy(md_busy), .stall_cycles(stall_cycles),
      .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // Model state: cycle index of the most recent mul/div start, and plain integer counters.
   int  cyc_n      = 0;
   int  last_start = 0;
   bit  start_vld  = 0;
   int  m_stall    = 0;
   int  m_flush    = 0;
   bit  e_stall, e_pc_wr, e_if_id_wr, e_flush, e_ls, e_hs, e_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_outs();
      bit lu, busy;
      busy = md_start || (start_vld && (cyc_n - last_start) < MD);
      lu = ex_memr && ex_regw && ex_rd != 0 &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      if (rst) begin
         {e_stall, e_pc_wr, e_if_id_wr, e_flush, e_ls, e_hs, e_busy} = 7'b1001000;
      end else begin
         e_busy = busy;
         e_ls = 0; e_hs = 0; e_flush = 0;
         if (ex_redirect) begin
            e_stall = 1; e_pc_wr = 1; e_if_id_wr = 1; e_flush = 1;
         end else if (id_uses_hilo && busy) begin
            e_stall = 1; e_pc_wr = 0; e_if_id_wr = 0; e_hs = 1; e_ls = lu;
         end else if (lu) begin
            e_stall = 1; e_pc_wr = 0; e_if_id_wr = 0; e_ls = 1;
         end else begin
            e_stall = 0; e_pc_wr = 1; e_if_id_wr = 1;
         end
      end
   endtask

   always @(posedge clk) begin
      model_outs();
      if (rst) begin
         start_vld = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (md_start) begin
            start_vld = 1; last_start = cyc_n;
         end
         if (cnt_clr) begin
            m_stall = 0; m_flush = 0;
         end else begin
            if (!e_pc_wr) m_stall = (m_stall == (1 << SW) - 1) ? m_stall : m_stall + 1;
            if (ex_redirect) m_flush = (m_flush == (1 << FW) - 1) ? m_flush : m_flush + 1;
         end
      end
      cyc_n++;
   end

   always @(negedge clk) begin
      model_outs();
      chk("STALL", 32'(STALL), 32'(e_stall));
      chk("pc_wr", 32'(pc_wr), 32'(e_pc_wr));
      chk("if_id_wr", 32'(if_id_wr), 32'(e_if_id_wr));
      chk("if_id_flush", 32'(if_id_flush), 32'(e_flush));
      chk("load_stall", 32'(load_stall), 32'(e_ls));
      chk("hilo_stall", 32'(hilo_stall), 32'(e_hs));
      chk("md_busy", 32'(md_busy), 32'(e_busy));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
      ex_memr = 0; ex_regw = 0; ex_redirect = 0; md_start = 0; cnt_clr = 0; rst = 0;
   endtask

   initial begin
      rst = 1;
      repeat (3) tick();
      @(negedge clk);
      chk("lit_rst_pc_wr", 32'(pc_wr), 32'd0);
      chk("lit_rst_flush", 32'(if_id_flush), 32'd1);
      tick();
      idle();

      // load-use
      ex_memr = 1; ex_regw = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
      @(negedge clk);
      chk("lit_lu_stall", 32'({STALL, pc_wr, if_id_wr, load_stall}), 32'b1001);
      tick(); idle();
      @(negedge clk);
      chk("lit_lu_release", 32'(pc_wr), 32'd1);
      chk("lit_lu_cnt", 32'(stall_cycles), 32'd1);
      tick();

      // register 0 and unused operand never hazard
      ex_memr = 1; ex_regw = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
      @(negedge clk);
      chk("lit_r0", 32'(pc_wr), 32'd1);
      tick();
      ex_rd = 5; id_rs = 5; id_uses_rs = 0;
      @(negedge clk);
      chk("lit_unused_rs", 32'(pc_wr), 32'd1);
      tick(); idle();

      // HI/LO interlock
      cnt_clr = 1; tick(); idle();
      md_start = 1; id_uses_hilo = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lit_hl_stall", 32'({hilo_stall, pc_wr}), 32'b10);
         tick(); md_start = 0;
      end
      @(negedge clk);
      chk("lit_hl_release", 32'(pc_wr), 32'd1);
      chk("lit_hl_cnt", 32'(stall_cycles), 32'd4);
      tick(); idle();

      // redirect overrides load-use
      cnt_clr = 1; tick(); idle();
      ex_redirect = 1; ex_memr = 1; ex_regw = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1;
      @(negedge clk);
      chk("lit_rd_prio", 32'({pc_wr, if_id_flush, STALL, load_stall}), 32'b1110);
      tick(); idle();
      @(negedge clk);
      chk("lit_rd_cnt", 32'(flush_cnt), 32'd1);

      // saturation then clear
      ex_redirect = 1;
      repeat (5) tick();
      @(negedge clk);
      chk("lit_fl_sat", 32'(flush_cnt), 32'd3);
      cnt_clr = 1;
      tick(); idle();
      @(negedge clk);
      chk("lit_fl_clr", 32'(flush_cnt), 32'd0);

      // reset mid-operation
      md_start = 1; tick(); md_start = 0; tick();
      rst = 1;
      @(negedge clk);
      chk("lit_mid_rst", 32'({STALL, pc_wr}), 32'b10);
      tick(); idle();
      id_uses_hilo = 1;
      @(negedge clk);
      chk("lit_post_rst", 32'({md_busy, pc_wr}), 32'b01);
      tick(); idle();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 99) == 0);
         cnt_clr      = ($urandom_range(0, 59) == 0);
         ex_redirect  = ($urandom_range(0, 7) == 0);
         md_start     = !ex_redirect && ($urandom_range(0, 9) == 0);
         id_uses_hilo = ($urandom_range(0, 3) == 0);
         ex_memr      = ($urandom_range(0, 2) == 0);
         ex_regw      = ($urandom_range(0, 3) != 0);
         ex_rd        = 5'($urandom_range(0, 3));
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         id_uses_rs   = 1'($urandom_range(0, 1));
         id_uses_rt   = 1'($urandom_range(0, 1));
         tick();
      end
      idle();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
